// File: rtl/i2c_init_sequencer_pkg.sv
// Shared encodings for the I2C power-up command sequencer.
// Engine handshake levels, status masks and FSM states.
package i2c_init_sequencer_pkg;

  localparam logic BUSY     = 1'b0;
  localparam logic NOT_BUSY = 1'b1;

  localparam logic [7:0] ADDR_ACK  = 8'h02;
  localparam logic [7:0] REG_ACK   = 8'h08;
  localparam logic [7:0] DATA_ACK  = 8'h20;
  localparam logic [7:0] STATUS_OK = ADDR_ACK | REG_ACK | DATA_ACK;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT_END,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/i2c_init_sequencer_rom.sv
// Fixed power-up table: {address byte, register, data} per index.
// Address byte is the 7-bit device address 0x3C shifted left, R/W=0.
module i2c_init_sequencer_rom (
  input  logic [3:0]  index,
  output logic [23:0] cmd
);

  always_comb begin
    cmd = 24'h000000;
    case (index)
      4'd0:    cmd = 24'h78_00_01;
      4'd1:    cmd = 24'h78_01_80;
      4'd2:    cmd = 24'h78_10_3F;
      4'd3:    cmd = 24'h78_11_0A;
      4'd4:    cmd = 24'h78_20_55;
      4'd5:    cmd = 24'h78_21_AA;
      4'd6:    cmd = 24'h78_30_07;
      4'd7:    cmd = 24'h78_31_01;
      default: cmd = 24'h000000;
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the command table, driving the single-byte I2C write engine
// with retry on NACK/timeout and held done/error reporting.
module i2c_init_sequencer
  import i2c_init_sequencer_pkg::*;
#(
  parameter int NUM_CMDS       = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic       clock_i2c,
  input  logic       reset,
  input  logic       start,
  output logic       enable_send,
  output logic [7:0] slave_address,
  output logic [7:0] slave_register,
  output logic [7:0] slave_data,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_status,
  output logic [3:0] cmd_index,
  output logic       done,
  output logic       error,
  output logic       led
);

  localparam logic [3:0] LAST = 4'(NUM_CMDS - 1);
  localparam logic [2:0] MAXR = 3'(MAX_RETRIES);
  localparam logic [3:0] GAPL = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO  = 8'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [2:0]  retry, retry_n;
  logic [7:0]  tmo, tmo_n;
  logic [3:0]  gap, gap_n;
  logic [7:0]  stat, stat_n;
  logic        tfail, tfail_n;
  logic        pass, pass_n;
  logic [23:0] cmd_q, cmd_n, rom_cmd;

  i2c_init_sequencer_rom u_rom (
    .index (idx),
    .cmd   (rom_cmd)
  );

  always_ff @(posedge clock_i2c) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= 4'd0;
      retry <= 3'd0;
      tmo   <= 8'd0;
      gap   <= 4'd0;
      stat  <= 8'd0;
      tfail <= 1'b0;
      pass  <= 1'b0;
      cmd_q <= 24'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      retry <= retry_n;
      tmo   <= tmo_n;
      gap   <= gap_n;
      stat  <= stat_n;
      tfail <= tfail_n;
      pass  <= pass_n;
      cmd_q <= cmd_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    retry_n     = retry;
    tmo_n       = tmo;
    gap_n       = gap;
    stat_n      = stat;
    tfail_n     = tfail;
    pass_n      = pass;
    cmd_n       = cmd_q;
    enable_send = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    led         = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        done  = (state == S_DONE);
        error = (state == S_ERROR);
        if (start) begin
          state_n = S_LOAD;
          idx_n   = 4'd0;
          retry_n = 3'd0;
        end
      end
      S_LOAD: begin
        led     = 1'b1;
        cmd_n   = rom_cmd;
        tmo_n   = 8'd0;
        tfail_n = 1'b0;
        state_n = S_REQ;
      end
      S_REQ: begin
        led         = 1'b1;
        enable_send = 1'b0;
        if (i2c_busy == BUSY) begin
          tmo_n   = 8'd0;
          state_n = S_WAIT_END;
        end else if (tmo == TMO) begin
          tfail_n = 1'b1;
          state_n = S_CHECK;
        end else begin
          tmo_n = tmo + 8'd1;
        end
      end
      S_WAIT_END: begin
        led         = 1'b1;
        enable_send = 1'b0;
        if (i2c_busy == NOT_BUSY) begin
          stat_n  = i2c_status;
          state_n = S_CHECK;
        end else if (tmo == TMO) begin
          tfail_n = 1'b1;
          state_n = S_CHECK;
        end else begin
          tmo_n = tmo + 8'd1;
        end
      end
      S_CHECK: begin
        led   = 1'b1;
        gap_n = 4'd0;
        if (!tfail && stat == STATUS_OK) begin
          retry_n = 3'd0;
          pass_n  = 1'b1;
          state_n = S_GAP;
        end else if (retry < MAXR) begin
          retry_n = retry + 3'd1;
          pass_n  = 1'b0;
          state_n = S_GAP;
        end else begin
          state_n = S_ERROR;
        end
      end
      S_GAP: begin
        led = 1'b1;
        if (gap == GAPL) begin
          if (!pass) begin
            state_n = S_LOAD;
          end else if (idx == LAST) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = S_LOAD;
          end
        end else begin
          gap_n = gap + 4'd1;
        end
      end
    endcase
  end

  assign slave_address  = cmd_q[23:16];
  assign slave_register = cmd_q[15:8];
  assign slave_data     = cmd_q[7:0];
  assign cmd_index      = idx;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench: engine model plus attempt/outcome queues
// checked by a monitor on enable_send and done/error edges.
module tb_i2c_init_sequencer;

  logic       clock_i2c = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       i2c_busy = 1'b1;
  logic [7:0] i2c_status = 8'h00;
  logic       enable_send;
  logic [7:0] slave_address;
  logic [7:0] slave_register;
  logic [7:0] slave_data;
  logic [3:0] cmd_index;
  logic       done;
  logic       error;
  logic       led;

  always #5 clock_i2c = ~clock_i2c;

  i2c_init_sequencer #(
    .NUM_CMDS       (3),
    .MAX_RETRIES    (3),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (127)
  ) dut (
    .clock_i2c      (clock_i2c),
    .reset          (reset),
    .start          (start),
    .enable_send    (enable_send),
    .slave_address  (slave_address),
    .slave_register (slave_register),
    .slave_data     (slave_data),
    .i2c_busy       (i2c_busy),
    .i2c_status     (i2c_status),
    .cmd_index      (cmd_index),
    .done           (done),
    .error          (error),
    .led            (led)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] d;
    logic [3:0] idx;
    int         gap;
    int         low;
  } att_t;

  typedef struct {
    logic       dn;
    logic       er;
    logic [3:0] idx;
  } out_t;

  att_t       att_q[$];
  out_t       out_q[$];
  logic [7:0] stat_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         hang = 1'b0;

  logic [7:0] rom_a [3] = '{8'h78, 8'h78, 8'h78};
  logic [7:0] rom_r [3] = '{8'h00, 8'h01, 8'h10};
  logic [7:0] rom_d [3] = '{8'h01, 8'h80, 8'h3F};

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic push_att(int idx, int gap, int low);
    att_t t;
    t.a   = rom_a[idx];
    t.r   = rom_r[idx];
    t.d   = rom_d[idx];
    t.idx = 4'(idx);
    t.gap = gap;
    t.low = low;
    att_q.push_back(t);
  endtask

  task automatic push_out(bit dn, bit er, int idx);
    out_t o;
    o.dn  = dn;
    o.er  = er;
    o.idx = 4'(idx);
    out_q.push_back(o);
  endtask

  task automatic pulse_start();
    @(negedge clock_i2c);
    start = 1'b1;
    @(negedge clock_i2c);
    start = 1'b0;
  endtask

  task automatic wait_run(int budget);
    int n = 0;
    while ((att_q.size() != 0 || out_q.size() != 0) && n < budget) begin
      @(negedge clock_i2c);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL wait_run timeout att=%0d out=%0d",
               att_q.size(), out_q.size());
      att_q.delete();
      out_q.delete();
    end
    repeat (3) @(negedge clock_i2c);
  endtask

  // Engine: busy drops 2 cycles after request, rises 57 cycles later.
  initial begin
    int est = 0;
    int cnt = 0;
    forever begin
      @(negedge clock_i2c);
      if (!reset) begin
        i2c_busy = 1'b1;
        est = 0;
        cnt = 0;
        stat_q.delete();
      end else begin
        case (est)
          0: if (!enable_send) begin est = 1; cnt = 0; end
          1: begin
            if (enable_send) est = 0;
            else if (!hang) begin
              cnt++;
              if (cnt == 2) begin
                i2c_busy = 1'b0;
                cnt = 0;
                est = 2;
              end
            end
          end
          2: begin
            cnt++;
            if (cnt == 57) begin
              i2c_status = (stat_q.size() != 0) ?
                           stat_q.pop_front() : 8'd42;
              i2c_busy = 1'b1;
              est = 3;
            end
          end
          default: if (enable_send) est = 0;
        endcase
      end
    end
  end

  initial begin
    att_t cur;
    out_t o;
    bit   have = 1'b0;
    int   hi = 0;
    int   lo = 0;
    logic pen = 1'b1;
    logic pfin = 1'b0;
    logic fin;
    forever begin
      @(negedge clock_i2c);
      if (!reset) begin
        hi = 0; lo = 0; pen = 1'b1; pfin = 1'b0; have = 1'b0;
      end else begin
        if (pen && !enable_send) begin
          if (att_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_attempt idx=%0d", cmd_index);
            have = 1'b0;
          end else begin
            cur = att_q.pop_front();
            have = 1'b1;
            check("att_addr", slave_address, cur.a);
            check("att_reg", slave_register, cur.r);
            check("att_data", slave_data, cur.d);
            check("att_idx", cmd_index, cur.idx);
            if (cur.gap >= 0) check("att_gap", hi, cur.gap);
          end
          lo = 0;
        end
        if (!pen && enable_send) begin
          if (have && cur.low >= 0) check("att_low", lo, cur.low);
          have = 1'b0;
          hi = 0;
        end
        if (enable_send) hi++;
        else lo++;
        fin = done | error;
        if (fin && !pfin) begin
          if (out_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_end done=%0b error=%0b", done, error);
          end else begin
            o = out_q.pop_front();
            check("end_done", done, o.dn);
            check("end_error", error, o.er);
            check("end_idx", cmd_index, o.idx);
            check("end_en", enable_send, 1);
            check("end_led", led, 0);
          end
        end
        pen = enable_send;
        pfin = fin;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clock_i2c);
    check("rst_en", enable_send, 1);
    check("rst_bytes", {slave_address, slave_register, slave_data}, 0);
    check("rst_idx", cmd_index, 0);
    check("rst_flags", {done, error, led}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock_i2c);
    check("idle_en", enable_send, 1);

    // happy path
    repeat (3) stat_q.push_back(8'd42);
    push_att(0, -1, 60);
    push_att(1, 6, 60);
    push_att(2, 6, 60);
    push_out(1, 0, 2);
    pulse_start();
    check("run_led", led, 1);
    wait_run(1000);

    // relaunch from DONE with start pulses mid-run
    repeat (3) stat_q.push_back(8'd42);
    push_att(0, -1, 60);
    push_att(1, 6, 60);
    push_att(2, 6, 60);
    push_out(1, 0, 2);
    pulse_start();
    check("relaunch_done", done, 0);
    repeat (20) @(negedge clock_i2c);
    pulse_start();
    repeat (100) @(negedge clock_i2c);
    pulse_start();
    wait_run(1000);

    // single NACK on entry 1
    stat_q.push_back(8'd42);
    stat_q.push_back(8'h26);
    stat_q.push_back(8'd42);
    stat_q.push_back(8'd42);
    push_att(0, -1, 60);
    push_att(1, 6, 60);
    push_att(1, 6, 60);
    push_att(2, 6, 60);
    push_out(1, 0, 2);
    pulse_start();
    wait_run(1000);

    // retry exhaustion on entry 2
    stat_q.push_back(8'd42);
    stat_q.push_back(8'd42);
    repeat (4) stat_q.push_back(8'h01);
    push_att(0, -1, 60);
    push_att(1, 6, 60);
    repeat (4) push_att(2, 6, 60);
    push_out(0, 1, 2);
    pulse_start();
    wait_run(1500);

    // engine never answers: four 128-cycle timeouts
    hang = 1'b1;
    push_att(0, -1, 128);
    repeat (3) push_att(0, 6, 128);
    push_out(0, 1, 0);
    pulse_start();
    wait_run(2000);
    hang = 1'b0;

    // reset during WAIT_END of entry 1
    stat_q.push_back(8'd42);
    push_att(0, -1, 60);
    push_att(1, 6, -1);
    pulse_start();
    n = 0;
    while (!(cmd_index == 4'd1 && !enable_send) && n < 500) begin
      @(negedge clock_i2c);
      n++;
    end
    check("mid_reached", n < 500, 1);
    repeat (10) @(negedge clock_i2c);
    reset = 1'b0;
    @(negedge clock_i2c);
    check("mid_en", enable_send, 1);
    check("mid_idx", cmd_index, 0);
    check("mid_bytes", {slave_address, slave_register, slave_data}, 0);
    check("mid_flags", {done, error, led}, 0);
    reset = 1'b1;
    check("mid_pending", att_q.size(), 0);
    att_q.delete();
    repeat (3) stat_q.push_back(8'd42);
    push_att(0, -1, 60);
    push_att(1, 6, 60);
    push_att(2, 6, 60);
    push_out(1, 0, 2);
    pulse_start();
    wait_run(1000);

    check("final_queues", att_q.size() + out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
